// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response handshake bundle for mem_access_unit
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/halfword/word load-store unit over a word-wide memory
module mem_access_unit #(
  parameter int ADDR_BITS = 10
) (
  input  logic               clk,
  input  logic               reset,
  mem_access_unit_if.slave   bus,
  output logic [31:0]        Address,
  output logic [31:0]        Write_data,
  output logic               MemRead,
  output logic               MemWrite,
  input  logic [31:0]        Mem_data
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic [31:0] cap_q;
  logic        req_err;

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] off,
                                               input logic [1:0] sz, input logic sg);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {off, 3'b000});
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   load_extract = sg ? {{24{b[7]}}, b} : {24'h0, b};
      2'b01:   load_extract = sg ? {{16{h[15]}}, h} : {16'h0, h};
      default: load_extract = w;
    endcase
  endfunction

  // Sub-word stores overlay only the addressed lane(s) onto the word captured in RD.
  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] off, input logic [1:0] sz);
    logic [31:0] r;
    r = w;
    case (sz)
      2'b00: begin
        case (off)
          2'd0:    r[7:0]   = d[7:0];
          2'd1:    r[15:8]  = d[7:0];
          2'd2:    r[23:16] = d[7:0];
          default: r[31:24] = d[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) r[31:16] = d[15:0];
        else        r[15:0]  = d[15:0];
      end
      default: r = d;
    endcase
    store_merge = r;
  endfunction

  always_comb begin
    req_err = 1'b0;
    case (bus.req_size)
      2'b01:   req_err = bus.req_addr[0];
      2'b10:   req_err = (bus.req_addr[1:0] != 2'b00);
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if ((bus.req_addr >> ADDR_BITS) != 32'd0) req_err = 1'b1;
  end

  assign bus.req_ready = (state == IDLE);
  assign Address       = {addr_q[31:2], 2'b00};
  assign Write_data    = store_merge(cap_q, wdata_q, addr_q[1:0], size_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      addr_q         <= '0;
      size_q         <= '0;
      signed_q       <= 1'b0;
      write_q        <= 1'b0;
      wdata_q        <= '0;
      cap_q          <= '0;
      MemRead        <= 1'b0;
      MemWrite       <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q   <= bus.req_addr;
            size_q   <= bus.req_size;
            signed_q <= bus.req_signed;
            write_q  <= bus.req_write;
            wdata_q  <= bus.req_wdata;
            if (req_err) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end else if (bus.req_write && bus.req_size == 2'b10) begin
              state    <= WR;
              MemWrite <= 1'b1;
            end else begin
              state   <= RD;
              MemRead <= 1'b1;
            end
          end
        end
        RD: begin
          cap_q   <= Mem_data;
          MemRead <= 1'b0;
          if (write_q) begin
            state    <= WR;
            MemWrite <= 1'b1;
          end else begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= load_extract(Mem_data, addr_q[1:0], size_q, signed_q);
          end
        end
        WR: begin
          MemWrite       <= 1'b0;
          state          <= RESP;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= '0;
        end
        RESP: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_data;

  int checks   = 0;
  int failures = 0;
  int rd_total = 0;
  int wr_total = 0;
  int both_cnt = 0;
  logic [31:0] last_wdata = '0;

  bit [31:0] mem [256];

  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  mem_access_unit #(.ADDR_BITS(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .Address    (address),
    .Write_data (write_data),
    .MemRead    (mem_read),
    .MemWrite   (mem_write),
    .Mem_data   (mem_data)
  );

  // Memory model: combinational read, write on the rising edge.
  assign mem_data = mem[address[9:2]];

  always @(posedge clk) begin
    if (mem_write) mem[address[9:2]] <= write_data;
    if (mem_read) rd_total <= rd_total + 1;
    if (mem_write) begin
      wr_total   <= wr_total + 1;
      last_wdata <= write_data;
    end
    if (mem_read && mem_write) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                     input int exp_nrd, input int exp_nwr);
    int lat, rd0, wr0;
    logic [31:0] rdata;
    logic err;
    @(negedge clk);
    check({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    rd0 = rd_total;
    wr0 = wr_total;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    @(posedge clk);
    @(negedge clk);
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".rdata"}, rdata, exp_rdata);
    check({tag, ".err"}, 32'(err), 32'(exp_err));
    check({tag, ".nrd"}, 32'(rd_total - rd0), 32'(exp_nrd));
    check({tag, ".nwr"}, 32'(wr_total - wr0), 32'(exp_nwr));
  endtask

  initial begin
    int rd0, wr0, lat;
    logic [31:0] hold_rdata;

    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    check("rst.req_ready", 32'(bus.req_ready), 32'd1);
    check("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst.resp_err", 32'(bus.resp_err), 32'd0);
    check("rst.resp_rdata", bus.resp_rdata, 32'd0);
    check("rst.memread", 32'(mem_read), 32'd0);
    check("rst.memwrite", 32'(mem_write), 32'd0);

    run("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB, 32'h0, 1'b0, 2, 0, 1);
    check("sw10.wdata", last_wdata, 32'h8899AABB);
    run("sw20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0, 2, 0, 1);

    run("lw10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 2, 1, 0);
    run("lbs13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFFFF88, 1'b0, 2, 1, 0);
    run("lbu13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h00000088, 1'b0, 2, 1, 0);
    run("lbs10", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 32'hFFFFFFBB, 1'b0, 2, 1, 0);
    run("lbu11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h000000AA, 1'b0, 2, 1, 0);
    run("lhs12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFF8899, 1'b0, 2, 1, 0);
    run("lhu10", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h0000AABB, 1'b0, 2, 1, 0);

    run("sh22", 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, 32'h0, 1'b0, 3, 1, 1);
    check("sh22.wdata", last_wdata, 32'hBEEF3344);
    run("lw20a", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hBEEF3344, 1'b0, 2, 1, 0);
    run("sb21", 1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFF5A, 32'h0, 1'b0, 3, 1, 1);
    check("sb21.wdata", last_wdata, 32'hBEEF5A44);
    run("lw20b", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hBEEF5A44, 1'b0, 2, 1, 0);

    run("err_lw21",  1'b0, 2'b10, 1'b0, 32'h21,       32'h0,        32'h0, 1'b1, 1, 0, 0);
    run("err_sh23",  1'b1, 2'b01, 1'b0, 32'h23,       32'h1234,     32'h0, 1'b1, 1, 0, 0);
    run("err_oor",   1'b0, 2'b10, 1'b0, 32'h400,      32'h0,        32'h0, 1'b1, 1, 0, 0);
    run("err_hi",    1'b1, 2'b10, 1'b0, 32'h80000000, 32'hCAFEF00D, 32'h0, 1'b1, 1, 0, 0);
    run("err_sz3",   1'b0, 2'b11, 1'b0, 32'h10,       32'h0,        32'h0, 1'b1, 1, 0, 0);

    // Backpressure: response held while a competing request is presented.
    @(negedge clk);
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b10;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h10;
    rd0 = rd_total;
    wr0 = wr_total;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("bp.lat", 32'(lat), 32'd2);
    hold_rdata     = bus.resp_rdata;
    check("bp.rdata", hold_rdata, 32'h8899AABB);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_size   = 2'b10;
    bus.req_addr   = 32'h30;
    bus.req_wdata  = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp.resp_valid", 32'(bus.resp_valid), 32'd1);
      check("bp.resp_rdata", bus.resp_rdata, 32'h8899AABB);
      check("bp.resp_err", 32'(bus.resp_err), 32'd0);
      check("bp.req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp.idle", 32'(bus.req_ready), 32'd1);
    check("bp.resp_valid_off", 32'(bus.resp_valid), 32'd0);
    check("bp.nrd", 32'(rd_total - rd0), 32'd1);
    check("bp.nwr", 32'(wr_total - wr0), 32'd0);
    run("lw30a", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h0, 1'b0, 2, 1, 0);

    // Reset while a byte store sits in its read phase.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h30;
    bus.req_wdata  = 32'h77;
    wr0 = wr_total;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rstrd.in_rd", 32'(mem_read), 32'd1);
    check("rstrd.addr", address, 32'h30);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rstrd.req_ready", 32'(bus.req_ready), 32'd1);
    check("rstrd.resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rstrd.memread", 32'(mem_read), 32'd0);
    check("rstrd.memwrite", 32'(mem_write), 32'd0);
    repeat (3) @(negedge clk);
    check("rstrd.no_resp", 32'(bus.resp_valid), 32'd0);
    check("rstrd.nwr", 32'(wr_total - wr0), 32'd0);
    run("lw30b", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h0, 1'b0, 2, 1, 0);

    check("never_both", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: ADDR_BITS, default 10, number of valid byte-address bits; any request address with a nonzero bit at or above ADDR_BITS is out of range.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  requester presents an access.
REQ-005 req_ready  output  1  unit accepts an access this cycle.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-008 req_signed  input  1  sign-extend sub-word loads.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  requester consumes the response.
REQ-013 resp_rdata  output  32  load result, extended; 0 for stores and errors.
REQ-014 resp_err  output  1  access was misaligned, out of range or illegal size.
REQ-015 Address  output  32  word address to memory, always {req_addr[31:2],2'b00}.
REQ-016 Write_data  output  32  word to memory.
REQ-017 MemRead  output  1  memory read enable; the memory returns Mem_data combinationally.
REQ-018 MemWrite  output  1  memory write enable; the memory writes on the next rising clk.
REQ-019 Mem_data  input  32  memory read word.

Function
REQ-020 States SHALL be IDLE, RD, WR, RESP.
REQ-021 req_ready SHALL be 1 only in IDLE.
REQ-022 Acceptance SHALL occur when req_valid and req_ready are both 1 at a rising edge; the unit latches addr, size, signed, write and wdata at acceptance.
REQ-023 An error check at acceptance SHALL flag misalignment (halfword with addr[0]=1; word with addr[1:0]≠0), size 11, or out of range.
REQ-024 An erroneous request SHALL go IDLE->RESP with resp_err=1, resp_rdata=0, and no MemRead or MemWrite pulse.
REQ-025 A load SHALL go IDLE->RD->RESP; in RD, MemRead=1 and Mem_data is captured at the end of the cycle.
REQ-026 A word store SHALL go IDLE->WR->RESP; in WR, MemWrite=1 for exactly one cycle with Write_data=wdata.
REQ-027 A byte or halfword store SHALL go IDLE->RD->WR->RESP, using read-modify-write to replace only the addressed lane(s).
REQ-028 Byte lanes SHALL be little-endian: offset 0 = bits[7:0], offset 3 = bits[31:24]; a halfword at offset 2 = bits[31:16].
REQ-029 Load extraction SHALL take the lane selected by addr[1:0], then zero-extend, or sign-extend when signed=1; word loads are passed unchanged.
REQ-030 Address SHALL be driven from the latched address in RD and WR; in IDLE and RESP, MemRead=MemWrite=0.
REQ-031 MemRead and MemWrite SHALL never both be 1.
REQ-032 In RESP, resp_valid=1; resp_rdata and resp_err SHALL hold stable until resp_ready=1, then the state goes to IDLE.
REQ-033 Latency from acceptance to first resp_valid SHALL be 2 cycles for loads and word stores, 3 cycles for sub-word stores, and 1 cycle for errors.
REQ-034 A req_valid in any state other than IDLE SHALL be ignored and not queued.
REQ-035 No back-to-back acceptance is possible: IDLE is re-entered at minimum one cycle after resp_ready.

Reset
REQ-036 Reset SHALL force IDLE, clear all latched request registers and the capture register, and drive resp_valid=0, resp_err=0, resp_rdata=0, MemRead=0 and MemWrite=0 on the following cycle.
REQ-037 Reset asserted in WR on the same edge SHALL still allow that edge's memory write, since MemWrite was already high; no further write SHALL occur afterwards.
REQ-038 Reset mid-transaction SHALL discard the transaction without producing a response.

Verification
REQ-039 Word load: memory word 0x10 = 0x8899AABB, load word at 0x10 -> one MemRead cycle, resp_rdata=0x8899AABB, resp_err=0, resp_valid 2 cycles after acceptance.
REQ-040 Signed/unsigned byte load: word 0x10 = 0x8899AABB, load byte at 0x13 -> resp_rdata=0xFFFFFF88 with signed=1 and 0x00000088 with signed=0.
REQ-041 Halfword store (RMW): word 0x20 = 0x11223344, store halfword 0xBEEF at 0x22 -> one MemRead then one MemWrite with Write_data=0xBEEF3344; a later load word at 0x20 returns 0xBEEF3344.
REQ-042 Errors: load word at 0x21, store halfword at 0x23, access at 0x400 (ADDR_BITS=10), size=11 -> each returns resp_err=1 after 1 cycle, with MemRead and MemWrite remaining 0 throughout.
REQ-043 Backpressure: hold resp_ready=0 for 5 cycles after resp_valid -> resp_valid, resp_rdata and resp_err stay constant, req_ready=0, and a new req_valid is ignored.
REQ-044 Reset in RD of a byte store -> no MemWrite occurs, no response is issued, and the unit is in IDLE with req_ready=1 the cycle after reset deasserts.
